lcd_char_ctrl: RTL and testbench

LCD_CHAR_CTRL -- requirements
Module: lcd_char_ctrl

---
 rtl/lcd_char_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lcd_char_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_ctrl.sv
// HD44780-style 4-bit LCD character controller: power-on init, configuration,
// then byte writes (upper nibble, lower nibble) through a handshake.
module lcd_char_ctrl #(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_4100  = 205000,
    parameter int unsigned T_100   = 5000,
    parameter int unsigned T_40    = 2000,
    parameter int unsigned T_CLEAR = 82000,
    parameter int unsigned T_E     = 12,
    parameter int unsigned T_SU    = 2,
    parameter int unsigned T_GAP   = 50,
    parameter int unsigned CNT_W   = 32
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_PULSE, INIT_WAIT, CFG_LOAD,
        WR_SETUP_HI, WR_E_HI, WR_GAP, WR_SETUP_LO, WR_E_LO, WR_WAIT, IDLE
    } state_t;

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_limit;
    logic             w_last;
    logic [1:0]       r_step, w_next_step;
    logic [1:0]       r_cfg_idx, w_next_cfg_idx;
    logic [7:0]       r_byte, w_next_byte, w_cfg_byte;
    logic             r_rs, w_next_rs;
    logic [3:0]       r_data, w_next_data;
    logic             r_init_done, w_next_init_done;

    always_comb begin
        w_limit = CNT_W'(1);
        unique case (r_state)
            PWR_WAIT:                     w_limit = CNT_W'(T_PWR);
            INIT_PULSE, WR_E_HI, WR_E_LO: w_limit = CNT_W'(T_E);
            INIT_WAIT: begin
                case (r_step)
                    2'd0:    w_limit = CNT_W'(T_4100);
                    2'd1:    w_limit = CNT_W'(T_100);
                    default: w_limit = CNT_W'(T_40);
                endcase
            end
            WR_SETUP_HI, WR_SETUP_LO:     w_limit = CNT_W'(T_SU);
            WR_GAP:                       w_limit = CNT_W'(T_GAP);
            WR_WAIT: begin
                // Clear display and return home need the long wait
                if (!r_rs && (r_byte == 8'h01 || r_byte == 8'h02))
                    w_limit = CNT_W'(T_CLEAR);
                else
                    w_limit = CNT_W'(T_40);
            end
            default:                      w_limit = CNT_W'(1);
        endcase
    end

    assign w_last = (r_cnt == w_limit - CNT_W'(1));

    always_comb begin
        case (r_cfg_idx)
            2'd0:    w_cfg_byte = 8'h28;
            2'd1:    w_cfg_byte = 8'h06;
            2'd2:    w_cfg_byte = 8'h0C;
            default: w_cfg_byte = 8'h01;
        endcase
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_step      = r_step;
        w_next_cfg_idx   = r_cfg_idx;
        w_next_byte      = r_byte;
        w_next_rs        = r_rs;
        w_next_data      = r_data;
        w_next_init_done = r_init_done;
        unique case (r_state)
            PWR_WAIT: if (w_last) begin
                w_next_state = INIT_PULSE;
                w_next_data  = 4'h3;
            end
            INIT_PULSE: if (w_last) w_next_state = INIT_WAIT;
            INIT_WAIT: if (w_last) begin
                if (r_step == 2'd3) begin
                    w_next_state = CFG_LOAD;
                end else begin
                    w_next_step  = r_step + 2'd1;
                    w_next_state = INIT_PULSE;
                    w_next_data  = (r_step == 2'd2) ? 4'h2 : 4'h3;
                end
            end
            CFG_LOAD: begin
                w_next_byte  = w_cfg_byte;
                w_next_rs    = 1'b0;
                w_next_data  = w_cfg_byte[7:4];
                w_next_state = WR_SETUP_HI;
            end
            WR_SETUP_HI: if (w_last) w_next_state = WR_E_HI;
            WR_E_HI:     if (w_last) w_next_state = WR_GAP;
            WR_GAP: if (w_last) begin
                w_next_state = WR_SETUP_LO;
                w_next_data  = r_byte[3:0];
            end
            WR_SETUP_LO: if (w_last) w_next_state = WR_E_LO;
            WR_E_LO:     if (w_last) w_next_state = WR_WAIT;
            WR_WAIT: if (w_last) begin
                if (r_init_done) begin
                    w_next_state = IDLE;
                end else if (r_cfg_idx == 2'd3) begin
                    w_next_state     = IDLE;
                    w_next_init_done = 1'b1;
                end else begin
                    w_next_cfg_idx = r_cfg_idx + 2'd1;
                    w_next_state   = CFG_LOAD;
                end
            end
            IDLE: if (iValid) begin
                w_next_byte  = iData;
                w_next_rs    = iRS;
                w_next_data  = iData[7:4];
                w_next_state = WR_SETUP_HI;
            end
            default: w_next_state = PWR_WAIT;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= PWR_WAIT;
            r_cnt       <= '0;
            r_step      <= '0;
            r_cfg_idx   <= '0;
            r_byte      <= '0;
            r_rs        <= 1'b0;
            r_data      <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_step      <= w_next_step;
            r_cfg_idx   <= w_next_cfg_idx;
            r_byte      <= w_next_byte;
            r_rs        <= w_next_rs;
            r_data      <= w_next_data;
            r_init_done <= w_next_init_done;
            // Holding at the last count keeps IDLE from ever wrapping
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (!w_last)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign oReady                  = (r_state == IDLE);
    assign oInitDone               = r_init_done;
    assign oLCD_Enabled            = (r_state == INIT_PULSE) || (r_state == WR_E_HI) ||
                                     (r_state == WR_E_LO);
    assign oLCD_RegisterSelect     = r_rs;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_Data               = r_data;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl: records every E pulse (nibble, RS, width,
// preceding low time) and compares against hand-computed sequences.
module tb_lcd_char_ctrl;

    localparam int unsigned T_PWR   = 20;
    localparam int unsigned T_4100  = 10;
    localparam int unsigned T_100   = 5;
    localparam int unsigned T_40    = 4;
    localparam int unsigned T_CLEAR = 8;
    localparam int unsigned T_E     = 3;
    localparam int unsigned T_SU    = 2;
    localparam int unsigned T_GAP   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rs_in = 1'b0;
    logic       valid_in = 1'b0;
    logic       rdy, init_done, lcd_e, lcd_rs, lcd_rw, lcd_sf;
    logic [3:0] lcd_d;

    always #5 clk = ~clk;

    lcd_char_ctrl #(
        .T_PWR(T_PWR), .T_4100(T_4100), .T_100(T_100), .T_40(T_40),
        .T_CLEAR(T_CLEAR), .T_E(T_E), .T_SU(T_SU), .T_GAP(T_GAP), .CNT_W(16)
    ) dut (
        .Clock(clk), .Reset(rst_n), .iData(data_in), .iRS(rs_in), .iValid(valid_in),
        .oReady(rdy), .oInitDone(init_done), .oLCD_Enabled(lcd_e),
        .oLCD_RegisterSelect(lcd_rs), .oLCD_ReadWrite(lcd_rw),
        .oLCD_StrataFlashControl(lcd_sf), .oLCD_Data(lcd_d)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled 1 ns after each rising edge
    int   ecnt, npulse, last_fall, rise_at, rdy_rise, done_rise;
    logic prev_e, prev_r, prev_d, pre_rs;
    logic [3:0] pre_data;
    int   p_data[64], p_rs[64], p_gap[64], p_width[64], p_stable[64], p_setup[64];

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            ecnt = 0; npulse = 0; last_fall = 0; rise_at = 0;
            rdy_rise = -1; done_rise = -1;
            prev_e = 1'b0; prev_r = 1'b0; prev_d = 1'b0;
            pre_data = 4'h0; pre_rs = 1'b0;
        end else begin
            ecnt++;
            if (npulse < 64) begin
                if (lcd_e && !prev_e) begin
                    rise_at = ecnt;
                    p_data[npulse]   = int'(lcd_d);
                    p_rs[npulse]     = int'(lcd_rs);
                    p_gap[npulse]    = ecnt - last_fall;
                    p_stable[npulse] = 1;
                    p_setup[npulse]  = (pre_data == lcd_d && pre_rs == lcd_rs) ? 1 : 0;
                end else if (lcd_e && prev_e) begin
                    if (p_data[npulse] != int'(lcd_d) || p_rs[npulse] != int'(lcd_rs))
                        p_stable[npulse] = 0;
                end else if (!lcd_e && prev_e) begin
                    p_width[npulse] = ecnt - rise_at;
                    last_fall = ecnt;
                    npulse++;
                end
            end
            if (rdy && !prev_r) rdy_rise = ecnt;
            if (init_done && !prev_d) done_rise = ecnt;
            prev_e = lcd_e; prev_r = rdy; prev_d = init_done;
            pre_data = lcd_d; pre_rs = lcd_rs;
        end
    end

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!rdy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, rdy, 1);
    endtask

    task automatic check_init(input string tag);
        int exp_nib[12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
        int exp_gap[12] = '{20, 10, 5, 4, 7, 4, 7, 4, 7, 4, 7, 4};
        int k = 0;
        while (!init_done && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_done"}, init_done, 1);
        check_eq({tag, "_npulse"}, npulse, 12);
        for (int i = 0; i < 12; i++) begin
            check_eq($sformatf("%s_nib%0d", tag, i), p_data[i], exp_nib[i]);
            check_eq($sformatf("%s_gap%0d", tag, i), p_gap[i], exp_gap[i]);
            check_eq($sformatf("%s_wid%0d", tag, i), p_width[i], T_E);
            check_eq($sformatf("%s_rs%0d", tag, i), p_rs[i], 0);
        end
        check_eq({tag, "_done_lat"}, done_rise - last_fall, T_CLEAR);
        check_eq({tag, "_rdy_lat"}, rdy_rise, done_rise);
        check_eq({tag, "_rdy"}, rdy, 1);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] d, input logic rs,
                              input int exp_wait, input bit poke);
        int np0;
        wait_ready({tag, "_rdy0"});
        np0 = npulse;
        valid_in = 1'b1; data_in = d; rs_in = rs;
        @(negedge clk);
        valid_in = 1'b0; data_in = ~d; rs_in = ~rs;
        check_eq({tag, "_rdy_drop"}, rdy, 0);
        if (poke) begin
            repeat (3) @(negedge clk);
            valid_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
        end
        wait_ready({tag, "_rdy1"});
        check_eq({tag, "_npulse"}, npulse, np0 + 2);
        check_eq({tag, "_hi"}, p_data[np0], int'(d[7:4]));
        check_eq({tag, "_lo"}, p_data[np0+1], int'(d[3:0]));
        check_eq({tag, "_rs_hi"}, p_rs[np0], int'(rs));
        check_eq({tag, "_rs_lo"}, p_rs[np0+1], int'(rs));
        check_eq({tag, "_wid_hi"}, p_width[np0], T_E);
        check_eq({tag, "_wid_lo"}, p_width[np0+1], T_E);
        check_eq({tag, "_gap"}, p_gap[np0+1], T_GAP + T_SU);
        check_eq({tag, "_setup"}, p_setup[np0] + p_setup[np0+1], 2);
        check_eq({tag, "_stable"}, p_stable[np0] + p_stable[np0+1], 2);
        check_eq({tag, "_wait"}, rdy_rise - last_fall, exp_wait);
        if (poke) begin
            repeat (10) @(negedge clk);
            check_eq({tag, "_no_extra"}, npulse, np0 + 2);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int np0;
        int k;
        repeat (3) @(negedge clk);
        check_eq("rst_e", lcd_e, 0);
        check_eq("rst_rs", lcd_rs, 0);
        check_eq("rst_data", lcd_d, 0);
        check_eq("rst_rdy", rdy, 0);
        check_eq("rst_done", init_done, 0);
        check_eq("rst_rw", lcd_rw, 0);
        check_eq("rst_sf", lcd_sf, 1);
        rst_n = 1'b1;

        check_init("init");

        write_byte("wr41", 8'h41, 1'b1, T_40, 1'b0);
        write_byte("clr", 8'h01, 1'b0, T_CLEAR, 1'b0);
        write_byte("home", 8'h02, 1'b0, T_CLEAR, 1'b0);
        write_byte("ddram", 8'h80, 1'b0, T_40, 1'b0);
        write_byte("poke", 8'h5A, 1'b1, T_40, 1'b1);

        // iValid held high across two bytes
        wait_ready("b2b_rdy0");
        np0 = npulse;
        valid_in = 1'b1; data_in = 8'h55; rs_in = 1'b1;
        @(negedge clk);
        check_eq("b2b_drop1", rdy, 0);
        wait_ready("b2b_idle");
        data_in = 8'h80; rs_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("b2b_drop2", rdy, 0);
        wait_ready("b2b_rdy1");
        repeat (10) @(negedge clk);
        check_eq("b2b_npulse", npulse, np0 + 4);
        check_eq("b2b_n0", p_data[np0], 5);
        check_eq("b2b_n1", p_data[np0+1], 5);
        check_eq("b2b_n2", p_data[np0+2], 8);
        check_eq("b2b_n3", p_data[np0+3], 0);
        check_eq("b2b_rs1", p_rs[np0+1], 1);
        check_eq("b2b_rs2", p_rs[np0+2], 0);
        check_eq("b2b_gap", p_gap[np0+2], T_40 + 1 + T_SU);

        // Reset during the first E-high of a write
        wait_ready("abort_rdy");
        valid_in = 1'b1; data_in = 8'h41; rs_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        k = 0;
        while (!lcd_e && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_e_hi", lcd_e, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_e", lcd_e, 0);
        check_eq("abort_data", lcd_d, 0);
        check_eq("abort_rs", lcd_rs, 0);
        check_eq("abort_rdy", rdy, 0);
        check_eq("abort_done", init_done, 0);
        repeat (3) @(negedge clk);
        check_eq("abort_hold_e", lcd_e, 0);
        rst_n = 1'b1;
        check_init("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
